// File: rtl/pixel_fetch.sv
// pixel_fetch: walks a double-banked RGB888 frame buffer and emits one HUB75E
// column word {r0,g0,b0,r1,g1,b1} per handshake, ordered row pair -> bit plane
// -> column. The bank toggles only at frame boundaries or while idle.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | counters parked at zero, waiting for en_i; pending swap applies
// RD_HI  | upper-half pixel address on the RAM port
// RD_LO  | lower-half pixel address on the RAM port, upper pixel captured
// CAP    | lower pixel arrives, bit-plane word formed, out_vld_o raised
// SEND   | word held stable until accepted; counters advance on handshake
module pixel_fetch #(
    parameter int COLS  = 64,
    parameter int ROWS  = 64,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS),
    localparam int PW = $clog2(ROWS / 2),
    localparam int BW = $clog2(DEPTH),
    localparam int AW = 1 + RW + CW
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          en_i,
    input  logic          fb_swap_i,
    output logic [AW-1:0] ram_rd_addr_o,
    input  logic [23:0]   ram_rd_data_i,
    output logic [5:0]    out_data_o,
    output logic [PW-1:0] out_row_o,
    output logic [BW-1:0] out_bit_o,
    output logic          out_last_o,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic          rd_bank_o,
    output logic          swap_ack_o,
    output logic          frame_done_o
);

    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, CAP, SEND} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [BW-1:0] bit_cnt;
    logic [PW-1:0] row;
    logic          pend;
    logic [23:0]   up_px;

    logic          col_max, bit_max, row_max, frame_end, swap_now;
    logic [CW-1:0] col_nxt;
    logic [BW-1:0] bit_nxt;
    logic [PW-1:0] row_nxt;
    logic [RW-1:0] row_lo;
    logic [5:0]    word;

    // select one bit plane of an 8-bit channel
    function automatic logic pick(input logic [7:0] ch, input logic [BW-1:0] b);
        return |(ch & (8'd1 << b));
    endfunction

    assign col_max   = (col == CW'(COLS - 1));
    assign bit_max   = (bit_cnt == BW'(DEPTH - 1));
    assign row_max   = (row == PW'(ROWS / 2 - 1));
    assign frame_end = col_max && bit_max && row_max;
    assign swap_now  = pend | fb_swap_i;

    assign col_nxt = col_max ? '0 : col + 1'b1;
    assign bit_nxt = !col_max ? bit_cnt : (bit_max ? '0 : bit_cnt + 1'b1);
    assign row_nxt = !(col_max && bit_max) ? row : (row_max ? '0 : row + 1'b1);
    assign row_lo  = RW'(row) + RW'(ROWS / 2);

    assign word = {pick(up_px[23:16], bit_cnt), pick(up_px[15:8], bit_cnt),
                   pick(up_px[7:0], bit_cnt),
                   pick(ram_rd_data_i[23:16], bit_cnt), pick(ram_rd_data_i[15:8], bit_cnt),
                   pick(ram_rd_data_i[7:0], bit_cnt)};

    // fetch sequencer: addresses, word capture, handshake, bank swap
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            col           <= '0;
            bit_cnt       <= '0;
            row           <= '0;
            pend          <= 1'b0;
            up_px         <= '0;
            ram_rd_addr_o <= '0;
            out_data_o    <= '0;
            out_row_o     <= '0;
            out_bit_o     <= '0;
            out_last_o    <= 1'b0;
            out_vld_o     <= 1'b0;
            rd_bank_o     <= 1'b0;
            swap_ack_o    <= 1'b0;
            frame_done_o  <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            swap_ack_o   <= 1'b0;
            pend         <= pend | fb_swap_i;
            case (state)
                IDLE: begin
                    col     <= '0;
                    bit_cnt <= '0;
                    row     <= '0;
                    if (swap_now) begin
                        rd_bank_o  <= ~rd_bank_o;
                        swap_ack_o <= 1'b1;
                        pend       <= 1'b0;
                    end
                    if (en_i) begin
                        state         <= RD_HI;
                        ram_rd_addr_o <= {rd_bank_o ^ swap_now, {RW{1'b0}}, {CW{1'b0}}};
                    end
                end
                RD_HI: begin
                    ram_rd_addr_o <= {rd_bank_o, row_lo, col};
                    state         <= RD_LO;
                end
                RD_LO: begin
                    up_px <= ram_rd_data_i;
                    state <= CAP;
                end
                CAP: begin
                    out_data_o <= word;
                    out_row_o  <= row;
                    out_bit_o  <= bit_cnt;
                    out_last_o <= col_max;
                    out_vld_o  <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (out_vld_o && out_rdy_i) begin
                        out_vld_o <= 1'b0;
                        col       <= col_nxt;
                        bit_cnt   <= bit_nxt;
                        row       <= row_nxt;
                        if (frame_end) begin
                            frame_done_o <= 1'b1;
                            if (swap_now) begin
                                rd_bank_o  <= ~rd_bank_o;
                                swap_ack_o <= 1'b1;
                                pend       <= 1'b0;
                            end
                            if (en_i) begin
                                state         <= RD_HI;
                                ram_rd_addr_o <= {rd_bank_o ^ swap_now, {RW{1'b0}}, {CW{1'b0}}};
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            state         <= RD_HI;
                            ram_rd_addr_o <= {rd_bank_o, RW'(row_nxt), col_nxt};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch at reduced geometry (16 columns, 8 rows, 8-bit depth)
// so several complete frames fit in a short run.
module tb_pixel_fetch;
    localparam int COLS   = 16;
    localparam int ROWS   = 8;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(ROWS);
    localparam int PW     = $clog2(ROWS / 2);
    localparam int BW     = $clog2(DEPTH);
    localparam int AW     = 1 + RW + CW;
    localparam int FRAME  = COLS * DEPTH * (ROWS / 2);
    localparam int BUDGET = 20000;

    logic          clk_i = 1'b0;
    logic          rst_n_i, en_i, fb_swap_i, out_rdy_i;
    logic [AW-1:0] ram_rd_addr_o;
    logic [23:0]   ram_rd_data_i;
    logic [5:0]    out_data_o;
    logic [PW-1:0] out_row_o;
    logic [BW-1:0] out_bit_o;
    logic          out_last_o, out_vld_o, rd_bank_o, swap_ack_o, frame_done_o;

    logic [23:0] mem [0:(1<<AW)-1];

    int   tests = 0, fails = 0, hs_cnt = 0, done_cnt = 0, idx = 0;
    logic bank_m = 1'b0, pend_m = 1'b0, exp_done = 1'b0, exp_ack = 1'b0;
    logic stall_prev = 1'b0, rdy_rand = 1'b0;
    logic [5:0]    sv_data;
    logic [PW-1:0] sv_row;
    logic [BW-1:0] sv_bit;
    logic          sv_last;

    pixel_fetch #(.COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .fb_swap_i(fb_swap_i),
        .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i),
        .out_data_o(out_data_o), .out_row_o(out_row_o), .out_bit_o(out_bit_o),
        .out_last_o(out_last_o), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
        .rd_bank_o(rd_bank_o), .swap_ack_o(swap_ack_o), .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    // synchronous frame buffer, one cycle read latency
    always @(posedge clk_i) ram_rd_data_i <= mem[ram_rd_addr_o];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"},  32'(out_vld_o), 0);
        chk({tag, "_data"}, 32'(out_data_o), 0);
        chk({tag, "_row"},  32'(out_row_o), 0);
        chk({tag, "_bit"},  32'(out_bit_o), 0);
        chk({tag, "_last"}, 32'(out_last_o), 0);
        chk({tag, "_addr"}, 32'(ram_rd_addr_o), 0);
        chk({tag, "_bank"}, 32'(rd_bank_o), 0);
        chk({tag, "_ack"},  32'(swap_ack_o), 0);
        chk({tag, "_done"}, 32'(frame_done_o), 0);
    endtask

    task automatic wait_hs(input int n);
        int i = 0;
        while (hs_cnt < n && i < BUDGET) begin @(posedge clk_i); i++; end
        chk("wait_handshakes", 32'(hs_cnt >= n), 1);
    endtask

    task automatic wait_done(input int n);
        int i = 0;
        while (done_cnt < n && i < BUDGET) begin @(posedge clk_i); i++; end
        chk("wait_frame_end", 32'(done_cnt >= n), 1);
    endtask

    task automatic wait_vld();
        int i = 0;
        while (!out_vld_o && i < BUDGET) begin @(posedge clk_i); #1; i++; end
        chk("wait_vld", 32'(out_vld_o), 1);
    endtask

    task automatic pulse_swap();
        #1 fb_swap_i = 1'b1;
        @(posedge clk_i);
        #1 fb_swap_i = 1'b0;
    endtask

    // random ready during the stall phase
    initial forever begin
        @(posedge clk_i);
        #1;
        if (rdy_rand) out_rdy_i = 1'($urandom_range(0, 1));
    end

    // reference model: word k of a frame is col=k%COLS, bit=(k/COLS)%DEPTH,
    // row=k/(COLS*DEPTH); checked on every handshake and every cycle for pulses
    initial begin : compare
        logic [AW-1:0] au, al;
        logic [23:0]   su, sl;
        logic [5:0]    ew;
        int            c, b, r;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                idx = 0; bank_m = 1'b0; pend_m = 1'b0;
                exp_done = 1'b0; exp_ack = 1'b0; stall_prev = 1'b0;
            end else begin
                chk("frame_done", 32'(frame_done_o), 32'(exp_done));
                chk("swap_ack", 32'(swap_ack_o), 32'(exp_ack));
                chk("rd_bank", 32'(rd_bank_o), 32'(bank_m));
                exp_done = 1'b0;
                exp_ack  = 1'b0;
                if (stall_prev) begin
                    chk("stall_vld", 32'(out_vld_o), 1);
                    chk("stall_data", 32'(out_data_o), 32'(sv_data));
                    chk("stall_row", 32'(out_row_o), 32'(sv_row));
                    chk("stall_bit", 32'(out_bit_o), 32'(sv_bit));
                    chk("stall_last", 32'(out_last_o), 32'(sv_last));
                end
                if (fb_swap_i) pend_m = 1'b1;
                if (out_vld_o && out_rdy_i) begin
                    c  = idx % COLS;
                    b  = (idx / COLS) % DEPTH;
                    r  = idx / (COLS * DEPTH);
                    au = AW'((int'(bank_m) << (RW + CW)) | (r << CW) | c);
                    al = AW'((int'(bank_m) << (RW + CW)) | ((r + ROWS / 2) << CW) | c);
                    su = mem[au] >> b;
                    sl = mem[al] >> b;
                    ew = {su[16], su[8], su[0], sl[16], sl[8], sl[0]};
                    chk("word_data", 32'(out_data_o), 32'(ew));
                    chk("word_row", 32'(out_row_o), 32'(r));
                    chk("word_bit", 32'(out_bit_o), 32'(b));
                    chk("word_last", 32'(out_last_o), 32'(c == COLS - 1));
                    hs_cnt++;
                    idx++;
                    if (idx == FRAME) begin
                        idx      = 0;
                        exp_done = 1'b1;
                        exp_ack  = pend_m;
                        bank_m   = bank_m ^ pend_m;
                        pend_m   = 1'b0;
                        done_cnt++;
                    end
                end
                stall_prev = out_vld_o && !out_rdy_i;
                sv_data = out_data_o;
                sv_row  = out_row_o;
                sv_bit  = out_bit_o;
                sv_last = out_last_o;
            end
        end
    end

    initial begin : main
        rst_n_i = 1'b0; en_i = 1'b1; fb_swap_i = 1'b0; out_rdy_i = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem[AW'((r << CW) | c)] = {8'(c * 4), 8'(r * 4), 8'h55};
        mem[AW'(0)]                = 24'hFF0000;
        mem[AW'((ROWS / 2) << CW)] = 24'h0000FF;
        for (int a = 0; a < (1 << (AW - 1)); a++)
            mem[AW'(a + (1 << (AW - 1)))] = ~mem[AW'(a)];

        repeat (2) @(posedge clk_i);
        #1 chk_all_zero("reset");
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // first word three cycles after leaving IDLE, then 4-cycle spacing
        for (int i = 0; i < 3; i++) begin @(posedge clk_i); #1 chk("lat_vld_low", 32'(out_vld_o), 0); end
        @(posedge clk_i); #1;
        chk("first_vld", 32'(out_vld_o), 1);
        chk("first_data", 32'(out_data_o), 32'(6'b100_001));
        chk("first_row", 32'(out_row_o), 0);
        chk("first_bit", 32'(out_bit_o), 0);
        chk("first_last", 32'(out_last_o), 0);
        for (int i = 0; i < 3; i++) begin @(posedge clk_i); #1 chk("gap_vld_low", 32'(out_vld_o), 0); end
        @(posedge clk_i); #1 chk("second_vld", 32'(out_vld_o), 1);

        // random back-pressure for the rest of the first line
        rdy_rand = 1'b1;
        wait_hs(COLS);
        #2 rdy_rand = 1'b0;
        out_rdy_i = 1'b1;
        wait_vld();
        chk("line2_bit", 32'(out_bit_o), 1);
        chk("line2_last", 32'(out_last_o), 0);

        // three requests within the frame collapse into one swap at its end
        wait_hs(200); pulse_swap();
        wait_hs(250); pulse_swap();
        wait_hs(300); pulse_swap();
        wait_done(1);
        #1;
        chk("f1_done", 32'(frame_done_o), 1);
        chk("f1_ack", 32'(swap_ack_o), 1);
        chk("f1_bank", 32'(rd_bank_o), 1);
        chk("f1_addr_msb", 32'(ram_rd_addr_o), 32'(1 << (RW + CW)));
        @(posedge clk_i); #1;
        chk("f1_done_pulse", 32'(frame_done_o), 0);
        chk("f1_ack_pulse", 32'(swap_ack_o), 0);

        // enable dropped mid-frame: frame still completes, then idle
        wait_hs(FRAME + 100);
        #1 en_i = 1'b0;
        wait_done(2);
        #1;
        chk("f2_done", 32'(frame_done_o), 1);
        chk("f2_ack", 32'(swap_ack_o), 0);
        chk("f2_bank", 32'(rd_bank_o), 1);
        for (int i = 0; i < 20; i++) begin @(posedge clk_i); #1 chk("idle_vld", 32'(out_vld_o), 0); end
        en_i = 1'b1;
        wait_vld();
        chk("restart_data", 32'(out_data_o), 32'(6'b011_110));
        chk("restart_row", 32'(out_row_o), 0);
        chk("restart_bit", 32'(out_bit_o), 0);

        // reset while a word is stalled in SEND
        wait_hs(hs_cnt + 5);
        #1 out_rdy_i = 1'b0;
        wait_vld();
        #1 rst_n_i = 1'b0;
        #1 chk_all_zero("midrst");
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        out_rdy_i = 1'b1;
        wait_vld();
        chk("post_rst_data", 32'(out_data_o), 32'(6'b100_001));
        chk("post_rst_bank", 32'(rd_bank_o), 0);
        chk("post_rst_row", 32'(out_row_o), 0);
        chk("post_rst_bit", 32'(out_bit_o), 0);
        wait_hs(hs_cnt + 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pixel_fetch.md
# pixel_fetch

Upstream feeder for `waveform_gen`: reads a double-banked RGB888 frame buffer through a one-cycle-latency synchronous read port and emits one 6-bit HUB75E column word (r0,g0,b0,r1,g1,b1) per handshake. Words are ordered row pair → bit plane → column, with row address, bit-plane index and end-of-line marker, so the downstream stage only shifts, latches and times OE. Runs continuously while enabled; swaps buffer bank only at frame boundaries.

## Interface
- `COLS`, 64, panel columns
- `ROWS`, 64, panel rows (upper half rows 0..ROWS/2-1, lower half ROWS/2..ROWS-1)
- `DEPTH`, 8, bits per colour channel
- `clk_i` in 1: clock
- `rst_n_i` in 1: reset. One clock; reset is asynchronous and active-low.
- `en_i` in 1: run enable, sampled at frame boundaries
- `fb_swap_i` in 1: one-cycle bank-swap request
- `ram_rd_addr_o` out 1+log2(ROWS)+log2(COLS): {bank,row,col}, 13 bits at defaults
- `ram_rd_data_i` in 24: pixel, R=[23:16], G=[15:8], B=[7:0], valid one cycle after address
- `out_data_o` out 6: {r0,g0,b0,r1,g1,b1}
- `out_row_o` out log2(ROWS/2): row-pair address (5 bits)
- `out_bit_o` out log2(DEPTH): bit-plane index (3 bits)
- `out_last_o` out 1: word is column COLS-1
- `out_vld_o` out 1: word valid
- `out_rdy_i` in 1: downstream accepts
- `rd_bank_o` out 1: bank currently being read
- `swap_ack_o` out 1: one-cycle pulse when bank toggles
- `frame_done_o` out 1: one-cycle pulse after last word of a frame is accepted

## Operation
- Counters: `col` 0..COLS-1 (fastest), `bit` 0..DEPTH-1 (LSB first), `row` 0..ROWS/2-1 (slowest). Each wraps to 0 and carries into the next.
- FSM states: IDLE, RD_HI, RD_LO, CAP, SEND.
- IDLE: counters zero; on `en_i`=1 → RD_HI.
- RD_HI: addr = {bank,row,col} → RD_LO.
- RD_LO: addr = {bank,row+ROWS/2,col}; register upper pixel → CAP.
- CAP: register lower pixel; form word from bit `bit` of each channel; set `out_vld_o` → SEND.
- SEND: hold all out_* stable until `out_vld_o`&&`out_rdy_i`; then advance counters, clear `out_vld_o`, → RD_HI; if that word was the last of the frame (col,bit,row all at max) pulse `frame_done_o`, apply pending swap, and → RD_HI if `en_i`=1 else IDLE.
- `fb_swap_i` sets a sticky pending flag; at frame end (or at any cycle in IDLE) `rd_bank_o` toggles, flag clears, `swap_ack_o` pulses. Multiple requests within one frame collapse to one swap. Request coincident with the applying edge is absorbed by that swap.
- `en_i` deassert mid-frame has no effect until frame end; the frame always completes.
- `out_last_o` = (col==COLS-1) for the presented word.

## Timing
- Reset values: all outputs 0, `ram_rd_addr_o`=0, state IDLE, bank 0, pending flag 0.
- Read latency exactly 1: data for address driven in cycle N sampled at end of N+1.
- Minimum 4 cycles per word (RD_HI, RD_LO, CAP, SEND with `out_rdy_i` held high); first `out_vld_o` 3 cycles after leaving IDLE.
- `ram_rd_addr_o` is don't-care outside RD_HI/RD_LO but holds last value.
- `frame_done_o` and `swap_ack_o` assert in the cycle after the final handshake, for exactly one cycle.
- Frame at defaults: 64×8×32 = 16384 words.
- Reset asserted mid-operation: immediate return to reset values; no partial word ever presented after release.

## Test plan
- Reset, `en_i`=1, `out_rdy_i`=1, RAM (bank 0) pixel (0,0)=0xFF0000, (32,0)=0x0000FF → first word after 3 cycles: data=6'b100_001, row=0, bit=0, last=0; next word at 4-cycle spacing.
- `out_rdy_i` toggled randomly over one line → 64 words, all fields stable while stalled, `out_last_o` only on 64th, col order 0..63, then bit advances to 1.
- Full frame with gradient fill (R=col·4, G=row·4, B=0x55) → 16384 words match reference model; `frame_done_o` single pulse; counters wrap to row 0, bit 0.
- `fb_swap_i` pulsed three times mid-frame → exactly one `swap_ack_o` at frame end, `rd_bank_o` 0→1, address MSB 1 on next frame.
- `en_i` dropped at word 100 → frame completes, enters IDLE, `out_vld_o` stays 0; re-assert → restarts at row 0, bit 0, col 0.
- `rst_n_i` low for 1 cycle while in SEND → all outputs 0 immediately; after release restarts from IDLE, bank 0.
